conv_stream_engine: RTL and testbench
=====================================

Name: conv_stream_engine

Overview:
Streaming multi-engine 2-D convolution block; the next generation of the convolution layer in the ML network path.
- Accepts a row-major activation stream through a valid/ready handshake and builds KxK windows in internal line buffers.
- Supports a runtime stride, per-engine bias, arithmetic right shift with saturation, and optional ReLU.
- Output is backpressured through a valid/ready handshake. Sits between the activation buffer and the pooling/next-layer stage.

Parameters:
Bits, 8, signed width of activations, weights and outputs
AccBits, 24, signed accumulator width; must be >= 2*Bits+$clog2(KernelSize*KernelSize)+1
EngineCount, 2, number of parallel kernels (output channels)
KernelSize, 3, square kernel edge K
MaxMatrixSize, 28, largest square input edge; sets line-buffer depth
ShiftBits, 4, width of the requantisation shift field

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  begin a frame; sampled only in IDLE
matrix_size_i  in  $clog2(MaxMatrixSize+1)  input edge N; latched on start
stride_i  in  2  stride S (1..3); latched on start
shift_i  in  ShiftBits  arithmetic right shift amount; latched on start
relu_en_i  in  1  clamp negative results to 0; latched on start
kernel_weights_i  in  [EngineCount][K*K][Bits]  signed weights, index 0 = top-left, row-major; latched on start
bias_i  in  [EngineCount][AccBits]  signed per-engine bias; latched on start
pixel_valid_i  in  1  pixel_i is valid
pixel_ready_o  out  1  block accepts a pixel this cycle
pixel_i  in  Bits  signed activation
out_valid_o  out  1  data_o holds a result
out_ready_i  in  1  consumer takes data_o
data_o  out  [EngineCount][Bits]  signed results, one per engine
busy_o  out  1  frame in progress
done_o  out  1  one-cycle pulse after the last output handshake
error_o  out  1  one-cycle pulse on an illegal start

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; line buffers, counters and pipeline valid bits cleared. Buffer contents need not be zeroed.
- States:
  - IDLE: start_i with legal config latches all config, zeroes row/col counters, goes to STREAM, busy_o=1.
  - Illegal config (N<K, N>MaxMatrixSize, or S==0) pulses error_o for 1 cycle and stays in IDLE.
  - STREAM: accepts N*N pixels. After the last pixel is accepted, goes to FLUSH.
  - FLUSH: waits until the pipeline is empty and the final output has handshaken, then goes to DONE.
  - DONE: done_o=1 for one cycle, busy_o=0, returns to IDLE.
- start_i outside IDLE is ignored. Config input changes after start have no effect on the running frame.
- Handshake rules:
  - Pixel transfer happens when pixel_valid_i && pixel_ready_o.
  - advance = !out_valid_o || out_ready_i.
  - pixel_ready_o = (state==STREAM) && advance.
  - The whole pipeline stalls when advance=0.
  - data_o and out_valid_o stay stable while out_valid_o && !out_ready_i.
- Window generation:
  - Uses K-1 line buffers of depth MaxMatrixSize, plus a KxK shift-register window.
  - Pixel (r,c) completes a window when r>=K-1, c>=K-1, (r-K+1)%S==0 and (c-K+1)%S==0.
  - Windows never wrap across row ends.
  - Outputs per frame: ((N-K)/S+1)^2 with integer division. Trailing rows/cols that do not fit are consumed and discarded.
- Arithmetic, per engine:
  - Stage 1: K*K signed Bits x Bits products, registered.
  - Stage 2: sum + bias in AccBits, then >>> shift_i (floor toward -inf).
  - Stage 2 continued: saturate to [-2^(Bits-1), 2^(Bits-1)-1], then ReLU if enabled. Result is registered into data_o.
- Latency: out_valid_o rises 2 cycles after the handshake of the window-completing pixel, when not stalled.
- Simultaneous events:
  - Last pixel handshake and output handshake in the same cycle are both honoured.
  - A done_o cycle with start_i asserted does not start a frame; start is sampled the next IDLE cycle.
- Reset mid-frame aborts immediately. No done_o pulse; the next frame needs a fresh start.
- pixel_valid_i while pixel_ready_o=0 is ignored (no data loss; the producer holds).

Test Plan:
1. N=5, K=3, S=1, shift=3, bias=0, relu off; engine0 weights 1..9; engine1 weights 10,-10,20,-20,30,-30,40,-40,50; pixels 0..24 with out_ready_i=1.
   - Expect 9 outputs.
   - First output: data_o[0]=45 (366>>3), data_o[1]=57 (460>>3).
   - Expect done_o once, busy_o low afterwards.
2. Same frame with shift=0.
   - Expect the first output to saturate to 127 on both engines.
   - Expect first out_valid_o exactly 2 cycles after handshake of pixel 12.
3. N=5, S=2.
   - Expect exactly 4 outputs, from windows at (0,0),(0,2),(2,0),(2,2).
   - Expect N=6, S=2 also to give 4 outputs, with row 5 and col 5 discarded.
4. Pixels 0,-1,...,-24 with engine0 weights 1..9 and relu on.
   - Expect all data_o[0]=0; with relu off, expect negative saturated values (-128).
5. Hold out_ready_i=0 for 6 cycles after the first out_valid_o.
   - Expect data_o stable, pixel_ready_o=0, and no lost or duplicated outputs (9 in total).
6. Illegal start with N=2, or with S=0: error_o pulses and busy_o stays 0. Separately, assert rst_ni low mid-frame after pixel 7: outputs clear and no done_o; a following legal frame reproduces the scenario 1 results.

Source files
------------

// File: rtl/conv_stream_engine.sv
// Streaming KxK 2-D convolution over a row-major pixel stream, EngineCount kernels in parallel.
// Two pipeline stages after the window: registered products, then bias/shift/saturate into data_o.
module conv_stream_engine #(
  parameter int unsigned Bits          = 8,
  parameter int unsigned AccBits       = 24,
  parameter int unsigned EngineCount   = 2,
  parameter int unsigned KernelSize    = 3,
  parameter int unsigned MaxMatrixSize = 28,
  parameter int unsigned ShiftBits     = 4,
  localparam int unsigned SizeW        = $clog2(MaxMatrixSize + 1),
  localparam int unsigned KK           = KernelSize * KernelSize
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      start_i,
  input  logic [SizeW-1:0]                          matrix_size_i,
  input  logic [1:0]                                stride_i,
  input  logic [ShiftBits-1:0]                      shift_i,
  input  logic                                      relu_en_i,
  input  logic [EngineCount-1:0][KK-1:0][Bits-1:0]  kernel_weights_i,
  input  logic [EngineCount-1:0][AccBits-1:0]       bias_i,
  input  logic                                      pixel_valid_i,
  output logic                                      pixel_ready_o,
  input  logic [Bits-1:0]                           pixel_i,
  output logic                                      out_valid_o,
  input  logic                                      out_ready_i,
  output logic [EngineCount-1:0][Bits-1:0]          data_o,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic                                      error_o
);

  typedef enum logic [1:0] {StIdle, StStream, StFlush, StDone} state_e;

  localparam logic [SizeW-1:0]          KLast  = SizeW'(KernelSize - 1);
  localparam logic [SizeW-1:0]          KSize  = SizeW'(KernelSize);
  localparam logic [SizeW-1:0]          MaxN   = SizeW'(MaxMatrixSize);
  localparam logic [SizeW-1:0]          OneN   = SizeW'(1);
  localparam logic signed [AccBits-1:0] SatMax = AccBits'((2 ** (Bits - 1)) - 1);
  localparam logic signed [AccBits-1:0] SatMin = ~SatMax;

  state_e state_q, state_d;

  logic [SizeW-1:0]                         size_q, size_d;
  logic [1:0]                               stride_q, stride_d;
  logic [ShiftBits-1:0]                     shift_q, shift_d;
  logic                                     relu_q, relu_d;
  logic [EngineCount-1:0][KK-1:0][Bits-1:0] weight_q, weight_d;
  logic [EngineCount-1:0][AccBits-1:0]      bias_q, bias_d;

  logic [SizeW-1:0] row_q, row_d, col_q, col_d;
  logic [1:0]       row_ph_q, row_ph_d, col_ph_q, col_ph_d;
  logic             error_q, error_d;

  logic [Bits-1:0] lb_q [KernelSize-1][MaxMatrixSize];
  logic [Bits-1:0] col_in [KernelSize];
  logic [Bits-1:0] win_q [KernelSize][KernelSize];
  logic [Bits-1:0] win_d [KernelSize][KernelSize];

  logic signed [2*Bits-1:0] prod_new [EngineCount][KK];
  logic signed [2*Bits-1:0] prod_q   [EngineCount][KK];
  logic signed [2*Bits-1:0] prod_d   [EngineCount][KK];
  logic                     v1_q, v1_d;

  logic [EngineCount-1:0][Bits-1:0] result;
  logic [EngineCount-1:0][Bits-1:0] data_q, data_d;
  logic                             out_valid_q, out_valid_d;

  logic             advance, pix_hs, legal, win_hit, at_last;
  logic [SizeW-1:0] size_m1;

  assign advance       = !out_valid_q || out_ready_i;
  assign pixel_ready_o = (state_q == StStream) && advance;
  assign pix_hs        = pixel_valid_i && pixel_ready_o;
  assign legal         = (matrix_size_i >= KSize) && (matrix_size_i <= MaxN) && (stride_i != 2'd0);
  assign size_m1       = size_q - OneN;
  assign at_last       = (row_q == size_m1) && (col_q == size_m1);
  // Phase counters replace (r-K+1)%S and (c-K+1)%S; they only run once the window is full.
  assign win_hit       = (row_q >= KLast) && (col_q >= KLast) &&
                         (row_ph_q == 2'd0) && (col_ph_q == 2'd0);

  // Control FSM, config latch and raster counters.
  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    stride_d = stride_q;
    shift_d  = shift_q;
    relu_d   = relu_q;
    weight_d = weight_q;
    bias_d   = bias_q;
    row_d    = row_q;
    col_d    = col_q;
    row_ph_d = row_ph_q;
    col_ph_d = col_ph_q;
    error_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (legal) begin
            size_d   = matrix_size_i;
            stride_d = stride_i;
            shift_d  = shift_i;
            relu_d   = relu_en_i;
            weight_d = kernel_weights_i;
            bias_d   = bias_i;
            row_d    = '0;
            col_d    = '0;
            row_ph_d = '0;
            col_ph_d = '0;
            state_d  = StStream;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StStream: begin
        if (pix_hs) begin
          if (col_q == size_m1) begin
            col_d    = '0;
            col_ph_d = '0;
            row_d    = row_q + OneN;
            if (row_q >= KLast) begin
              row_ph_d = (row_ph_q == stride_q - 2'd1) ? 2'd0 : row_ph_q + 2'd1;
            end
            if (at_last) state_d = StFlush;
          end else begin
            col_d = col_q + OneN;
            if (col_q >= KLast) begin
              col_ph_d = (col_ph_q == stride_q - 2'd1) ? 2'd0 : col_ph_q + 2'd1;
            end
          end
        end
      end
      StFlush: begin
        if (!v1_q && !out_valid_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Window next state: shift left one column, new column = line buffers (oldest on top) + pixel.
  always_comb begin
    for (int i = 0; i < int'(KernelSize) - 1; i++) begin
      col_in[i] = lb_q[int'(KernelSize) - 2 - i][col_q];
    end
    col_in[KernelSize-1] = pixel_i;
    for (int i = 0; i < int'(KernelSize); i++) begin
      for (int j = 0; j < int'(KernelSize) - 1; j++) begin
        win_d[i][j] = win_q[i][j+1];
      end
      win_d[i][KernelSize-1] = col_in[i];
    end
  end

  // Products are taken from the next window so the result lands two cycles after the pixel.
  always_comb begin
    for (int e = 0; e < int'(EngineCount); e++) begin
      for (int k = 0; k < int'(KK); k++) begin
        prod_new[e][k] = (2*Bits)'($signed(win_d[k / int'(KernelSize)][k % int'(KernelSize)])) *
                         (2*Bits)'($signed(weight_q[e][k]));
      end
    end
  end

  always_comb begin
    for (int e = 0; e < int'(EngineCount); e++) begin
      logic signed [AccBits-1:0] acc;
      logic signed [AccBits-1:0] sat;
      acc = $signed(bias_q[e]);
      for (int k = 0; k < int'(KK); k++) begin
        acc = acc + AccBits'(prod_q[e][k]);
      end
      sat = acc >>> shift_q;
      if (sat > SatMax) sat = SatMax;
      if (sat < SatMin) sat = SatMin;
      if (relu_q && sat[AccBits-1]) sat = '0;
      result[e] = sat[Bits-1:0];
    end
  end

  // Whole pipeline holds while the output register is full and not taken.
  always_comb begin
    v1_d        = v1_q;
    prod_d      = prod_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    if (advance) begin
      v1_d        = pix_hs && win_hit;
      out_valid_d = v1_q;
      if (pix_hs && win_hit) prod_d = prod_new;
      if (v1_q) data_d = result;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      size_q      <= '0;
      stride_q    <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      weight_q    <= '0;
      bias_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      row_ph_q    <= '0;
      col_ph_q    <= '0;
      error_q     <= 1'b0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      for (int i = 0; i < int'(KernelSize); i++) begin
        for (int j = 0; j < int'(KernelSize); j++) win_q[i][j] <= '0;
      end
      for (int e = 0; e < int'(EngineCount); e++) begin
        for (int k = 0; k < int'(KK); k++) prod_q[e][k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      stride_q    <= stride_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      weight_q    <= weight_d;
      bias_q      <= bias_d;
      row_q       <= row_d;
      col_q       <= col_d;
      row_ph_q    <= row_ph_d;
      col_ph_q    <= col_ph_d;
      error_q     <= error_d;
      v1_q        <= v1_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      prod_q      <= prod_d;
      if (pix_hs) win_q <= win_d;
    end
  end

  // Line buffer j holds row r-1-j, indexed by column.
  always_ff @(posedge clk_i) begin
    if (pix_hs) begin
      lb_q[0][col_q] <= pixel_i;
      for (int j = 1; j < int'(KernelSize) - 1; j++) begin
        lb_q[j][col_q] <= lb_q[j-1][col_q];
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign data_o      = data_q;
  assign busy_o      = (state_q == StStream) || (state_q == StFlush);
  assign done_o      = (state_q == StDone);
  assign error_o     = error_q;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Self-checking bench for conv_stream_engine: directed scenarios plus randomized frames
// compared against a plain-arithmetic convolution model.
module tb_conv_stream_engine;
  localparam int Bits = 8, AccBits = 24, E = 2, K = 3, MaxN = 28, ShiftBits = 4;
  localparam int SizeW = 5, KK = 9;

  logic                             clk_i = 1'b0;
  logic                             rst_ni = 1'b0;
  logic                             start_i = 1'b0;
  logic [SizeW-1:0]                 matrix_size_i = '0;
  logic [1:0]                       stride_i = '0;
  logic [ShiftBits-1:0]             shift_i = '0;
  logic                             relu_en_i = 1'b0;
  logic [E-1:0][KK-1:0][Bits-1:0]   kernel_weights_i = '0;
  logic [E-1:0][AccBits-1:0]        bias_i = '0;
  logic                             pixel_valid_i = 1'b0;
  logic                             pixel_ready_o;
  logic [Bits-1:0]                  pixel_i = '0;
  logic                             out_valid_o;
  logic                             out_ready_i = 1'b1;
  logic [E-1:0][Bits-1:0]           data_o;
  logic                             busy_o, done_o, error_o;

  always #5 clk_i = ~clk_i;

  conv_stream_engine #(
    .Bits(Bits), .AccBits(AccBits), .EngineCount(E), .KernelSize(K),
    .MaxMatrixSize(MaxN), .ShiftBits(ShiftBits)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .matrix_size_i(matrix_size_i),
    .stride_i(stride_i), .shift_i(shift_i), .relu_en_i(relu_en_i),
    .kernel_weights_i(kernel_weights_i), .bias_i(bias_i), .pixel_valid_i(pixel_valid_i),
    .pixel_ready_o(pixel_ready_o), .pixel_i(pixel_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .data_o(data_o), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o)
  );

  int tests_run = 0;
  int tests_failed = 0;

  int w [E][KK];
  int bias [E];
  int pix [784];
  int got0[$], got1[$], exp0[$], exp1[$];
  int done_cnt, first_valid_cyc, stall_viol, ready_viol;
  int hs_cyc [784];

  // Reference model: direct convolution over every stride-aligned window origin.
  function automatic int requant(longint v, int sh, bit relu);
    longint d;
    longint q;
    d = longint'(1) << sh;
    if (v >= 0) q = v / d;
    else q = -((-v + d - 1) / d);
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    if (relu && q < 0) q = 0;
    return int'(q);
  endfunction

  task automatic build_expected(input int n, input int s, input int sh, input bit relu);
    longint acc [E];
    exp0.delete();
    exp1.delete();
    for (int r0 = 0; r0 + K <= n; r0 += s) begin
      for (int c0 = 0; c0 + K <= n; c0 += s) begin
        for (int e = 0; e < E; e++) begin
          acc[e] = bias[e];
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
              acc[e] += longint'(pix[(r0 + i) * n + c0 + j]) * w[e][i * K + j];
        end
        exp0.push_back(requant(acc[0], sh, relu));
        exp1.push_back(requant(acc[1], sh, relu));
      end
    end
  endtask

  task automatic set_scenario1;
    int w1 [KK] = '{10, -10, 20, -20, 30, -30, 40, -40, 50};
    for (int k = 0; k < KK; k++) begin
      w[0][k] = k + 1;
      w[1][k] = w1[k];
    end
    bias[0] = 0;
    bias[1] = 0;
    for (int i = 0; i < 25; i++) pix[i] = i;
  endtask

  // Drives one frame and records what the DUT produced. mode: 0 ready, 1 random, 2 hold 6.
  task automatic run_frame(input int n, input int s, input int sh, input bit relu,
                           input int mode, input int abort_after);
    int idx, cyc, hold;
    bit prev_stall, seen_done;
    logic [2*Bits-1:0] prev_data;
    got0.delete();
    got1.delete();
    done_cnt = 0;
    first_valid_cyc = -1;
    stall_viol = 0;
    ready_viol = 0;
    matrix_size_i = SizeW'(n);
    stride_i = 2'(s);
    shift_i = ShiftBits'(sh);
    relu_en_i = relu;
    for (int e = 0; e < E; e++) begin
      for (int k = 0; k < KK; k++) kernel_weights_i[e][k] = 8'(w[e][k]);
      bias_i[e] = 24'(bias[e]);
    end
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    // Config inputs wander during the frame; the DUT must use the latched copy.
    matrix_size_i = SizeW'($urandom);
    stride_i = 2'($urandom);
    shift_i = ShiftBits'($urandom);
    relu_en_i = ~relu;
    kernel_weights_i = {E * KK{8'($urandom)}};
    bias_i = {E{24'($urandom)}};
    idx = 0;
    cyc = 0;
    hold = 0;
    prev_stall = 1'b0;
    seen_done = 1'b0;
    prev_data = '0;
    while (!seen_done && cyc < 4000 && !(abort_after >= 0 && idx >= abort_after)) begin
      pixel_valid_i = (idx < n * n) && (mode != 1 || $urandom_range(0, 3) != 0);
      pixel_i = (idx < n * n) ? 8'(pix[idx]) : 8'd0;
      case (mode)
        1: out_ready_i = ($urandom_range(0, 2) != 0);
        2: out_ready_i = (hold >= 6);
        default: out_ready_i = 1'b1;
      endcase
      @(negedge clk_i);
      if (prev_stall && (!out_valid_o || data_o !== prev_data)) stall_viol++;
      if (out_valid_o && !out_ready_i && pixel_ready_o) ready_viol++;
      prev_stall = out_valid_o && !out_ready_i;
      prev_data = data_o;
      if (out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid_o && mode == 2) hold++;
      if (out_valid_o && out_ready_i) begin
        got0.push_back(int'($signed(data_o[0])));
        got1.push_back(int'($signed(data_o[1])));
      end
      if (pixel_valid_i && pixel_ready_o) begin
        hs_cyc[idx] = cyc;
        idx++;
      end
      if (done_o) begin
        done_cnt++;
        seen_done = 1'b1;
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    pixel_valid_i = 1'b0;
    out_ready_i = 1'b1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if ({out_valid_o, done_o, error_o, busy_o, pixel_ready_o, data_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got %b want 0",
               {out_valid_o, done_o, error_o, busy_o, pixel_ready_o, data_o});
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if (busy_o !== 1'b0 || pixel_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle busy=%b ready=%b want 0 0", busy_o, pixel_ready_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_basic;
    set_scenario1();
    build_expected(5, 1, 3, 1'b0);
    run_frame(5, 1, 3, 1'b0, 0, -1);
    tests_run++;
    if (got0.size() !== 9) begin
      tests_failed++;
      $display("FAIL basic_count got %0d want 9", got0.size());
    end
    tests_run++;
    if (got0.size() == 0 || got0[0] !== 45 || got1[0] !== 57) begin
      tests_failed++;
      $display("FAIL basic_first got %0d/%0d want 45/57",
               got0.size() ? got0[0] : 0, got1.size() ? got1[0] : 0);
    end
    for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
      tests_run++;
      if (got0[i] !== exp0[i] || got1[i] !== exp1[i]) begin
        tests_failed++;
        $display("FAIL basic_out[%0d] got %0d/%0d want %0d/%0d", i, got0[i], got1[i],
                 exp0[i], exp1[i]);
      end
    end
    @(negedge clk_i);
    tests_run++;
    if (done_cnt !== 1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done done_cnt=%0d busy=%b done=%b want 1 0 0", done_cnt, busy_o,
               done_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_saturate_latency;
    set_scenario1();
    build_expected(5, 1, 0, 1'b0);
    run_frame(5, 1, 0, 1'b0, 0, -1);
    tests_run++;
    if (got0.size() == 0 || got0[0] !== 127 || got1[0] !== 127) begin
      tests_failed++;
      $display("FAIL sat_first got %0d/%0d want 127/127",
               got0.size() ? got0[0] : 0, got1.size() ? got1[0] : 0);
    end
    tests_run++;
    if (first_valid_cyc - hs_cyc[12] !== 2) begin
      tests_failed++;
      $display("FAIL latency got %0d want 2", first_valid_cyc - hs_cyc[12]);
    end
    tests_run++;
    if (got0.size() !== exp0.size()) begin
      tests_failed++;
      $display("FAIL sat_count got %0d want %0d", got0.size(), exp0.size());
    end
    for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
      tests_run++;
      if (got0[i] !== exp0[i] || got1[i] !== exp1[i]) begin
        tests_failed++;
        $display("FAIL sat_out[%0d] got %0d/%0d want %0d/%0d", i, got0[i], got1[i],
                 exp0[i], exp1[i]);
      end
    end
  endtask

  task automatic test_stride;
    for (int n = 5; n <= 6; n++) begin
      for (int i = 0; i < n * n; i++) pix[i] = int'($urandom_range(0, 255)) - 128;
      build_expected(n, 2, 5, 1'b0);
      run_frame(n, 2, 5, 1'b0, 0, -1);
      tests_run++;
      if (got0.size() !== 4 || exp0.size() !== 4) begin
        tests_failed++;
        $display("FAIL stride_count n=%0d got %0d want 4", n, got0.size());
      end
      for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
        tests_run++;
        if (got0[i] !== exp0[i] || got1[i] !== exp1[i]) begin
          tests_failed++;
          $display("FAIL stride_out n=%0d [%0d] got %0d/%0d want %0d/%0d", n, i, got0[i],
                   got1[i], exp0[i], exp1[i]);
        end
      end
    end
  endtask

  task automatic test_relu;
    set_scenario1();
    for (int i = 0; i < 25; i++) pix[i] = -i;
    for (int r = 1; r >= 0; r--) begin
      build_expected(5, 1, 0, r[0]);
      run_frame(5, 1, 0, r[0], 0, -1);
      tests_run++;
      if (got0.size() !== 9) begin
        tests_failed++;
        $display("FAIL relu_count relu=%0d got %0d want 9", r, got0.size());
      end
      for (int i = 0; i < got0.size(); i++) begin
        tests_run++;
        if (got0[i] !== (r ? 0 : -128) || got1[i] !== exp1[i]) begin
          tests_failed++;
          $display("FAIL relu_out relu=%0d [%0d] got %0d/%0d want %0d/%0d", r, i, got0[i],
                   got1[i], r ? 0 : -128, exp1[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    set_scenario1();
    build_expected(5, 1, 3, 1'b0);
    run_frame(5, 1, 3, 1'b0, 2, -1);
    tests_run++;
    if (got0.size() !== 9) begin
      tests_failed++;
      $display("FAIL bp_count got %0d want 9", got0.size());
    end
    tests_run++;
    if (stall_viol !== 0 || ready_viol !== 0) begin
      tests_failed++;
      $display("FAIL bp_stall unstable=%0d ready_high=%0d want 0 0", stall_viol, ready_viol);
    end
    for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
      tests_run++;
      if (got0[i] !== exp0[i] || got1[i] !== exp1[i]) begin
        tests_failed++;
        $display("FAIL bp_out[%0d] got %0d/%0d want %0d/%0d", i, got0[i], got1[i],
                 exp0[i], exp1[i]);
      end
    end
  endtask

  task automatic test_illegal;
    int ns [3] = '{2, 5, 29};
    int ss [3] = '{1, 0, 1};
    for (int t = 0; t < 3; t++) begin
      matrix_size_i = SizeW'(ns[t]);
      stride_i = 2'(ss[t]);
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      @(negedge clk_i);
      tests_run++;
      if (error_o !== 1'b1 || busy_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL illegal_pulse n=%0d s=%0d error=%b busy=%b want 1 0", ns[t], ss[t],
                 error_o, busy_o);
      end
      @(posedge clk_i); #1;
      @(negedge clk_i);
      tests_run++;
      if (error_o !== 1'b0 || busy_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL illegal_after n=%0d s=%0d error=%b busy=%b want 0 0", ns[t], ss[t],
                 error_o, busy_o);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset_midframe;
    int dones;
    set_scenario1();
    run_frame(5, 1, 3, 1'b0, 0, 8);
    rst_ni = 1'b0;
    #1;
    tests_run++;
    if ({out_valid_o, busy_o, pixel_ready_o, done_o, data_o} !== '0 || done_cnt !== 0) begin
      tests_failed++;
      $display("FAIL midreset_clear got %b done_cnt=%0d want 0",
               {out_valid_o, busy_o, pixel_ready_o, done_o, data_o}, done_cnt);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (done_o || busy_o) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL midreset_nodone got %0d busy/done cycles want 0", dones);
    end
    @(posedge clk_i); #1;
    build_expected(5, 1, 3, 1'b0);
    run_frame(5, 1, 3, 1'b0, 0, -1);
    tests_run++;
    if (got0.size() !== 9 || done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL midreset_frame outputs=%0d done=%0d want 9 1", got0.size(), done_cnt);
    end
    for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
      tests_run++;
      if (got0[i] !== exp0[i] || got1[i] !== exp1[i]) begin
        tests_failed++;
        $display("FAIL midreset_out[%0d] got %0d/%0d want %0d/%0d", i, got0[i], got1[i],
                 exp0[i], exp1[i]);
      end
    end
  endtask

  task automatic test_random;
    int n, s, sh;
    bit relu;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(3, 8);
      s = $urandom_range(1, 3);
      sh = $urandom_range(0, 10);
      relu = 1'($urandom);
      for (int e = 0; e < E; e++) begin
        for (int k = 0; k < KK; k++) w[e][k] = int'($urandom_range(0, 255)) - 128;
        bias[e] = int'($urandom_range(0, 6000)) - 3000;
      end
      for (int i = 0; i < n * n; i++) pix[i] = int'($urandom_range(0, 255)) - 128;
      build_expected(n, s, sh, relu);
      run_frame(n, s, sh, relu, 1, -1);
      tests_run++;
      if (got0.size() !== exp0.size() || done_cnt !== 1) begin
        tests_failed++;
        $display("FAIL rand_count f=%0d n=%0d s=%0d got %0d done=%0d want %0d 1", f, n, s,
                 got0.size(), done_cnt, exp0.size());
      end
      for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
        tests_run++;
        if (got0[i] !== exp0[i] || got1[i] !== exp1[i]) begin
          tests_failed++;
          $display("FAIL rand_out f=%0d [%0d] got %0d/%0d want %0d/%0d", f, i, got0[i],
                   got1[i], exp0[i], exp1[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate_latency();
    test_stride();
    test_relu();
    test_backpressure();
    test_illegal();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
